// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch unit, instruction memory, the instruction register and execute.
// The master side is the fetch unit; the slave side is its environment.
interface instr_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, ir_out, ir_pc, ir_valid,
    input  mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ir_out, ir_pc, ir_valid,
    output mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch front end: owns the PC, fetches over req/ack and
// hands each word with its address to the instruction register over valid/ready.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master fetchBus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [15:0] pc_q,      pc_d;
  logic [15:0] addr_q,    addr_d;
  logic [15:0] irOut_q,   irOut_d;
  logic [15:0] irPc_q,    irPc_d;
  logic        irValid_q, irValid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= 16'h0000;
      irOut_q   <= 16'h0000;
      irPc_q    <= 16'h0000;
      irValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      irOut_q   <= irOut_d;
      irPc_q    <= irPc_d;
      irValid_q <= irValid_d;
    end
  end

  // Redirect is tested first in every state so it always beats ack and ready.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    irOut_d   = irOut_q;
    irPc_d    = irPc_q;
    irValid_d = irValid_q;
    case (state_q)
      FETCH: begin
        if (fetchBus.redirect) begin
          pc_d = fetchBus.redirect_pc;
          if (!fetchBus.mem_ack) begin
            addr_d  = pc_q;
            state_d = DRAIN;
          end
        end else if (fetchBus.mem_ack) begin
          irOut_d   = fetchBus.mem_rdata;
          irPc_d    = pc_q;
          pc_d      = pc_q + 16'h0001;
          irValid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      DRAIN: begin
        if (fetchBus.redirect) begin
          pc_d = fetchBus.redirect_pc;
        end
        if (fetchBus.mem_ack) begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (fetchBus.redirect) begin
          pc_d      = fetchBus.redirect_pc;
          irValid_d = 1'b0;
          state_d   = FETCH;
        end else if (fetchBus.ir_ready) begin
          irValid_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Request depends only on state and reset, never on mem_ack, so it cannot glitch off an ack.
  assign fetchBus.mem_req  = !rst && (state_q != HOLD);
  assign fetchBus.mem_addr = (state_q == DRAIN) ? addr_q : pc_q;
  assign fetchBus.ir_out   = irOut_q;
  assign fetchBus.ir_pc    = irPc_q;
  assign fetchBus.ir_valid = irValid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one record per clock cycle,
// followed by a hand-written reset-during-wait sequence.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;

  instr_fetch_if fetchBus ();

  instr_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetchBus (fetchBus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [15:0] redirectPc;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expOut;
    logic [15:0] expPc;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic addVec(input logic rd, input logic [15:0] rpc, input logic ack,
                        input logic [15:0] rdata, input logic ready, input logic eReq,
                        input logic [15:0] eAddr, input logic eValid,
                        input logic [15:0] eOut, input logic [15:0] ePc);
    vec_t v;
    v.redirect = rd;   v.redirectPc = rpc; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.expReq = eReq;   v.expAddr = eAddr;  v.expValid = eValid;
    v.expOut = eOut;   v.expPc = ePc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    fetchBus.redirect    = v.redirect;
    fetchBus.redirect_pc = v.redirectPc;
    fetchBus.mem_ack     = v.ack;
    fetchBus.mem_rdata   = v.rdata;
    fetchBus.ir_ready    = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic eReq, input logic [15:0] eAddr,
                            input logic eValid, input logic [15:0] eOut, input logic [15:0] ePc);
    checkOutput({tag, " mem_req"}, {15'd0, fetchBus.mem_req}, {15'd0, eReq});
    if (eReq) checkOutput({tag, " mem_addr"}, fetchBus.mem_addr, eAddr);
    checkOutput({tag, " ir_valid"}, {15'd0, fetchBus.ir_valid}, {15'd0, eValid});
    checkOutput({tag, " ir_out"}, fetchBus.ir_out, eOut);
    checkOutput({tag, " ir_pc"}, fetchBus.ir_pc, ePc);
  endtask

  initial begin
    // Columns: redirect, redirect_pc, ack, rdata, ready | req, addr, valid, ir_out, ir_pc
    // Zero-wait stream from 0100 with data = addr ^ A5A5.
    addVec(0, 16'h0000, 1, 16'hA4A5, 1,  1, 16'h0100, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'hA4A5, 16'h0100);
    addVec(0, 16'h0000, 1, 16'hA4A4, 1,  1, 16'h0101, 0, 16'hA4A5, 16'h0100);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'hA4A4, 16'h0101);
    // Three wait cycles at 0102.
    addVec(0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0102, 0, 16'hA4A4, 16'h0101);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0102, 0, 16'hA4A4, 16'h0101);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0102, 0, 16'hA4A4, 16'h0101);
    addVec(0, 16'h0000, 1, 16'h1234, 1,  1, 16'h0102, 0, 16'hA4A4, 16'h0101);
    // Backpressure for five cycles, then accept.
    for (int i = 0; i < 5; i++)
      addVec(0, 16'h0000, 1, 16'hFFFF, 0,  0, 16'h0000, 1, 16'h1234, 16'h0102);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'h1234, 16'h0102);
    addVec(0, 16'h0000, 1, 16'h5555, 1,  1, 16'h0103, 0, 16'h1234, 16'h0102);
    // Redirect in HOLD with ready high: instruction dropped, fetch at 2000.
    addVec(1, 16'h2000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'h5555, 16'h0103);
    addVec(0, 16'h0000, 1, 16'hAAAA, 1,  1, 16'h2000, 0, 16'h5555, 16'h0103);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'hAAAA, 16'h2000);
    // Redirect coinciding with ack: data discarded, stay in FETCH at 0105.
    addVec(1, 16'h0105, 1, 16'hDEAD, 1,  1, 16'h2001, 0, 16'hAAAA, 16'h2000);
    // Redirect to 3000 while 0105 is pending, then 4000 during drain.
    addVec(1, 16'h3000, 0, 16'h0000, 1,  1, 16'h0105, 0, 16'hAAAA, 16'h2000);
    addVec(1, 16'h4000, 0, 16'h0000, 1,  1, 16'h0105, 0, 16'hAAAA, 16'h2000);
    addVec(0, 16'h0000, 1, 16'hBEEF, 1,  1, 16'h0105, 0, 16'hAAAA, 16'h2000);
    addVec(0, 16'h0000, 1, 16'h4444, 1,  1, 16'h4000, 0, 16'hAAAA, 16'h2000);
    // Redirect to FFFF, then the PC wraps to 0000.
    addVec(1, 16'hFFFF, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h4444, 16'h4000);
    addVec(0, 16'h0000, 1, 16'h0F0F, 1,  1, 16'hFFFF, 0, 16'h4444, 16'h4000);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'h0F0F, 16'hFFFF);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0000, 0, 16'h0F0F, 16'hFFFF);
    addVec(0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0000, 0, 16'h0F0F, 16'hFFFF);

    rst = 1'b1;
    fetchBus.redirect    = 1'b0;
    fetchBus.redirect_pc = 16'h0000;
    fetchBus.mem_ack     = 1'b0;
    fetchBus.mem_rdata   = 16'h0000;
    fetchBus.ir_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkState("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                 vecs[i].expValid, vecs[i].expOut, vecs[i].expPc);
      @(negedge clk);
    end

    // Reset asserted while the fetch of 0000 is still waiting.
    rst = 1'b1;
    fetchBus.mem_ack = 1'b0;
    #1;
    checkState("rstMidWait", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Restart at 0100 with three wait cycles before the ack.
    for (int i = 0; i < 4; i++) begin
      fetchBus.mem_ack   = (i == 3);
      fetchBus.mem_rdata = (i == 3) ? 16'hA4A5 : 16'h0000;
      fetchBus.ir_ready  = 1'b1;
      #1;
      checkState($sformatf("wait%0d", i), 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
    end
    fetchBus.mem_ack = 1'b0;
    #1;
    checkState("afterWait", 1'b0, 16'h0000, 1'b1, 16'hA4A5, 16'h0100);
    @(negedge clk);
    #1;
    checkState("nextFetch", 1'b1, 16'h0101, 1'b0, 16'hA4A5, 16'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch front end for the 16-bit CPU datapath. Owns the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents each fetched word, with its address, to the instruction register through a valid/ready handshake. Accepts branch/jump redirects from execute and discards any in-flight fetch from the old path. It feeds the instruction register; the IR only captures what this block delivers.

## Interface

- RESET_PC, 16'h0000, first fetch address after reset

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  16  word address of the request
- mem_ack  in  1  memory returns mem_rdata this cycle, valid only while mem_req=1
- mem_rdata  in  16  instruction word, sampled when mem_req & mem_ack
- ir_out  out  16  fetched instruction to the instruction register
- ir_pc  out  16  address of ir_out
- ir_valid  out  1  ir_out/ir_pc hold an unconsumed instruction
- ir_ready  in  1  consumer accepts; transfer when ir_valid & ir_ready at a rising edge
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch address, sampled when redirect=1

## Operation

- Registers: pc (next fetch address), addr_q (abandoned request address), ir_out, ir_pc, ir_valid, 2-bit state.
- States: FETCH, HOLD, DRAIN.
- FETCH: mem_req=1, mem_addr=pc.
  - mem_ack & !redirect: ir_out<=mem_rdata, ir_pc<=pc, pc<=pc+1, ir_valid<=1, go HOLD.
  - redirect & mem_ack: data discarded, pc<=redirect_pc, stay FETCH.
  - redirect & !mem_ack: addr_q<=pc, pc<=redirect_pc, go DRAIN.
  - Otherwise hold; mem_addr stays stable until ack.
- DRAIN: mem_req=1, mem_addr=addr_q; keeps the abandoned request alive until acknowledged.
  - mem_ack: data discarded, go FETCH.
  - redirect: pc<=redirect_pc; latest redirect wins.
- HOLD: mem_req=0, ir_valid=1, outputs stable.
  - ir_ready & !redirect: ir_valid<=0, go FETCH.
  - redirect: ir_valid<=0, pc<=redirect_pc, go FETCH. ir_ready is ignored, so the instruction is not consumed.
- Redirect has priority over mem_ack and ir_ready in every state.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000, with no flag.
- mem_req and mem_addr are combinational from state and registers. No glitch paths from mem_ack to mem_req.
- Reset (asynchronous, any state): state=FETCH, pc=RESET_PC, addr_q=0, ir_out=16'h0000, ir_pc=16'h0000, ir_valid=0.
  - mem_req is 0 while rst=1 and rises in the first cycle after release.
  - An outstanding memory request is abandoned; the memory must tolerate this.

## Timing

- Zero-wait memory (ack in the same cycle as req): instruction valid 1 cycle after the request cycle.
- Throughput is at most one instruction per 2 cycles (FETCH, HOLD) with ir_ready held high.
- N memory wait cycles add N cycles of latency.
- ir_valid rises on the edge that samples the ack. ir_out and ir_pc change only on that edge or on reset.
- Redirect to the first new-path request: 1 cycle from FETCH or HOLD. From a pending FETCH it is 1 cycle plus the remaining wait for the abandoned ack.
- No path from mem_rdata to ir_out bypasses a register.

## Test plan

1. Reset release, RESET_PC=16'h0100, zero-wait memory returning data=addr^16'hA5A5, ir_ready=1 -> mem_addr sequence 0100, 0101, 0102. ir_out=A4A5 with ir_pc=0100, then A4A4 with ir_pc=0101. ir_valid pulses every 2 cycles.
2. Memory with 3 wait cycles at addr 0100 -> mem_req high and mem_addr=0100 for 4 cycles. ir_valid rises after the 4th cycle.
3. Backpressure: ir_ready=0 for 5 cycles in HOLD -> ir_out/ir_pc/ir_valid stable, mem_req=0. On ir_ready=1 the next fetch goes to 0101.
4. Redirect to 16'h2000 in HOLD with ir_ready=1 in the same cycle -> ir_valid drops, next mem_addr=2000, the old instruction never transfers.
5. Redirect to 16'h3000 during a FETCH of 0105 with 2 remaining wait cycles -> mem_addr=0105 held until ack, its data is never presented, then mem_addr=3000. A second redirect to 16'h4000 during DRAIN -> fetch resumes at 4000.
6. Wrap: redirect to 16'hFFFF -> ir_pc=FFFF delivered, next mem_addr=0000. Assert rst mid-wait -> immediate ir_valid=0 and mem_req=0. After release, fetch restarts at RESET_PC.
